// File: rtl/preact_pkg.sv
// ---------------------------------------------------------------------------
// preact_pkg
//
// Shared definitions for the streaming pre-activation unit:
//   - preact_state_t : two-state FSM encoding (ACCUM gathers beats, DONE
//                      presents the result until the consumer takes it)
//   - beats()        : number of input beats per vector (N / LANES)
//   - int_w()        : internal accumulator width, wide enough that the sum
//                      of N full-width products plus the bias never overflows
//
// The optional saturating output is selected by the PREACT_SAT_EN macro in
// preactivation_stream; nothing in this package depends on it.
// ---------------------------------------------------------------------------
package preact_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } preact_state_t;

  function automatic int beats(input int n, input int lanes);
    return n / lanes;
  endfunction

  // 2*DATA_WIDTH for one product, $clog2(N) for N-term growth, +1 for the bias.
  function automatic int int_w(input int n, input int data_width);
    return 2 * data_width + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/preact_lane_dot.sv
// ---------------------------------------------------------------------------
// preact_lane_dot
//
// Purely combinational LANES-wide signed dot product. Each lane multiplies
// two DATA_WIDTH signed operands to a full 2*DATA_WIDTH product; the products
// are sign-extended to OUT_W and summed.
//
// Ports:
//   x        in  LANES*DATA_WIDTH  packed signed operands, lane k at
//                                  [k*DATA_WIDTH +: DATA_WIDTH]
//   w        in  LANES*DATA_WIDTH  packed signed weights, same packing
//   lane_sum out OUT_W             signed sum of the LANES products
// ---------------------------------------------------------------------------
module preact_lane_dot
  import preact_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_W      = 19
) (
  input  logic [LANES*DATA_WIDTH-1:0] x,
  input  logic [LANES*DATA_WIDTH-1:0] w,
  output logic signed [OUT_W-1:0]     lane_sum
);

  logic signed [2*DATA_WIDTH-1:0] prod [LANES];

  // NOTE: combinational blocks use blocking '=' so the running sum is seen
  // by the next loop iteration within the same evaluation.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first; a path that
    // leaves it unassigned would infer a latch.
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      // Both operands are signed and the target is 2*DATA_WIDTH wide, so the
      // product is exact.
      prod[k]  = $signed(x[k*DATA_WIDTH +: DATA_WIDTH]) *
                 $signed(w[k*DATA_WIDTH +: DATA_WIDTH]);
      lane_sum = lane_sum + OUT_W'(prod[k]);
    end
  end

endmodule

// File: rtl/preactivation_stream.sv
// ---------------------------------------------------------------------------
// preactivation_stream
//
// Streaming pre-activation for one neuron:
//   pre = sum(x[i]*w[i], i = 0..N-1) + b
// The N-element vectors arrive LANES elements per beat over a valid/ready
// input; the result is presented on a valid/ready output. Input and output
// never overlap: while a result is pending the unit accepts no beats.
//
// Parameters:
//   N          vector length, a multiple of LANES
//   LANES      element pairs consumed per beat
//   DATA_WIDTH signed operand width
//   ACC_WIDTH  signed output width
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   beat present on x/w/b
//   in_ready   out  unit accepts a beat this cycle (registered state only)
//   x, w       in   LANES*DATA_WIDTH packed signed operands / weights
//   b          in   signed bias, sampled only on the first beat of a vector
//   out_valid  out  pre holds a completed result
//   out_ready  in   consumer takes the result
//   pre        out  ACC_WIDTH signed pre-activation
//   out_sat    out  result was clamped (only with PREACT_SAT_EN)
//
// Configuration macro:
//   PREACT_SAT_EN  defined   -> pre saturates to the ACC_WIDTH signed range
//                               and out_sat reports clamping
//                  undefined -> pre is the low ACC_WIDTH bits (wrap), no
//                               out_sat port
// ---------------------------------------------------------------------------
module preactivation_stream
  import preact_pkg::*;
#(
  parameter int N          = 4,
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] x,
  input  logic [LANES*DATA_WIDTH-1:0] w,
  input  logic [DATA_WIDTH-1:0]       b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        pre
`ifdef PREACT_SAT_EN
  ,
  output logic                        out_sat
`endif
);

  localparam int BEATS = beats(N, LANES);
  localparam int INT_W = int_w(N, DATA_WIDTH);
  // A single-beat vector still needs a 1-bit counter to keep the port legal.
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Elaboration-time guard: a partial last beat is not supported.
  if ((N % LANES) != 0) begin : g_bad_lanes
    $error("preactivation_stream: N (%0d) must be a multiple of LANES (%0d)", N, LANES);
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  preact_state_t           state;
  logic [CNT_W-1:0]        cnt;
  logic signed [INT_W-1:0] acc;

  logic signed [INT_W-1:0] lane_sum;
  logic                    beat_acc;
  logic                    last_beat;

  preact_lane_dot #(
    .LANES      (LANES),
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_W      (INT_W)
  ) u_lane_dot (
    .x        (x),
    .w        (w),
    .lane_sum (lane_sum)
  );

  // Handshake outputs decode the registered state only, so there is no
  // combinational path from out_ready (or any input) to in_ready/out_valid.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  assign beat_acc  = in_valid && in_ready;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the accumulator is a plain register, not a memory, so it is reset
    // along with the FSM; this is what makes pre read 0 out of reset.
    if (!rst_n) begin
      state <= ACCUM;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (beat_acc) begin
            // The first beat of a vector overwrites the previous result, so
            // acc never needs clearing between vectors.
            if (cnt == '0) begin
              acc <= INT_W'($signed(b)) + lane_sum;
            end else begin
              acc <= acc + lane_sum;
            end

            if (last_beat) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt   <= cnt + CNT_W'(1);
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state <= ACCUM;
          end
        end

        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output conversion. pre is a function of acc only; it is stable for the
  // whole DONE period because acc cannot change until the FSM leaves DONE.
  // -------------------------------------------------------------------------
`ifdef PREACT_SAT_EN
  // Compare in a width that holds both acc and the ACC_WIDTH limits.
  localparam int CMP_W = ((INT_W > ACC_WIDTH) ? INT_W : ACC_WIDTH) + 1;
  localparam logic signed [CMP_W-1:0] SAT_MAX =
    {{(CMP_W - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN =
    {{(CMP_W - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};

  logic signed [CMP_W-1:0] acc_x;
  logic                    sat_hi;
  logic                    sat_lo;

  always_comb begin
    acc_x  = CMP_W'(acc);
    sat_hi = (acc_x > SAT_MAX);
    sat_lo = (acc_x < SAT_MIN);

    if (sat_hi) begin
      pre = SAT_MAX[ACC_WIDTH-1:0];
    end else if (sat_lo) begin
      pre = SAT_MIN[ACC_WIDTH-1:0];
    end else begin
      pre = acc_x[ACC_WIDTH-1:0];
    end

    // Only meaningful alongside a presented result.
    out_sat = out_valid && (sat_hi || sat_lo);
  end
`else
  // Two's-complement wrap (or sign extension if ACC_WIDTH exceeds INT_W).
  assign pre = ACC_WIDTH'(acc);
`endif

endmodule

// File: tb/tb_preactivation_stream.sv
// ---------------------------------------------------------------------------
// tb_preactivation_stream
//
// Directed bench for preactivation_stream with default parameters
// (N=4, LANES=2, DATA_WIDTH=8, ACC_WIDTH=16). Expected results come from a
// small integer model and are queued when a vector is driven, then popped
// and compared when the unit presents its result. Handles both the default
// wrap build and the PREACT_SAT_EN build.
// ---------------------------------------------------------------------------
module tb_preactivation_stream;

  localparam int N     = 4;
  localparam int LANES = 2;
  localparam int DW    = 8;
  localparam int AW    = 16;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               in_valid  = 1'b0;
  logic               in_ready;
  logic [LANES*DW-1:0] x        = '0;
  logic [LANES*DW-1:0] w        = '0;
  logic [DW-1:0]      b         = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [AW-1:0]      pre;
`ifdef PREACT_SAT_EN
  logic               out_sat;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [AW-1:0] pre;
    logic          sat;
  } exp_t;

  exp_t sb[$];

  preactivation_stream #(
    .N          (N),
    .LANES      (LANES),
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pre       (pre)
`ifdef PREACT_SAT_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference model: exact integer sum, then wrap or clamp to AW bits.
  function automatic exp_t model(input int s);
    exp_t e;
`ifdef PREACT_SAT_EN
    if (s > 32767) begin
      e.pre = 16'h7fff;
      e.sat = 1'b1;
    end else if (s < -32768) begin
      e.pre = 16'h8000;
      e.sat = 1'b1;
    end else begin
      e.pre = AW'(s);
      e.sat = 1'b0;
    end
`else
    e.pre = AW'(s);
    e.sat = 1'b0;
`endif
    return e;
  endfunction

  // Drive one accepted beat, then leave garbage on the data inputs.
  task automatic send_beat(input string tag, input int xa, input int xb,
                           input int wa, input int wb, input int bias);
    in_valid = 1'b1;
    x        = {DW'(xb), DW'(xa)};
    w        = {DW'(wb), DW'(wa)};
    b        = DW'(bias);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    x        = 16'($urandom);
    w        = 16'($urandom);
    b        = 8'($urandom);
  endtask

  // Queue the expected result, then send both beats with 'gap' idle cycles
  // between them. The second beat carries a random bias, which must be ignored.
  task automatic send_vec(input string tag,
                          input int x0, input int x1, input int x2, input int x3,
                          input int w0, input int w1, input int w2, input int w3,
                          input int bias, input int gap);
    sb.push_back(model(x0*w0 + x1*w1 + x2*w2 + x3*w3 + bias));
    send_beat({tag, "_b0"}, x0, x1, w0, w1, bias);
    check({tag, "_mid_valid"}, 32'(out_valid), 32'd0);
    repeat (gap) tick();
    send_beat({tag, "_b1"}, x2, x3, w2, w3, int'($urandom_range(0, 255)));
    check({tag, "_latency"}, 32'(out_valid), 32'd1);
  endtask

  // Wait (bounded) for a result, compare against the scoreboard, release it.
  // With keep set, out_ready is left high afterwards.
  task automatic collect(input string tag, input bit keep, output int at);
    exp_t e;
    int   n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
    at = cycle;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_pre"}, 32'(pre), 32'(e.pre));
`ifdef PREACT_SAT_EN
      check({tag, "_sat"}, 32'(out_sat), 32'(e.sat));
`endif
    end
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    if (!keep) out_ready = 1'b0;
    check({tag, "_released"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int t0;
    int t1;

    // Reset values.
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pre", 32'(pre), 32'd0);
`ifdef PREACT_SAT_EN
    check("rst_out_sat", 32'(out_sat), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // out_ready while idle must do nothing.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_ready", 32'(out_valid), 32'd0);

    // Basic: 1*5 + 2*6 + 3*7 + 4*8 + 10 = 80.
    send_vec("basic", 1, 2, 3, 4, 5, 6, 7, 8, 10, 0);
    collect("basic", 1'b0, t0);

    // Overflow: 4 * (-128*127) - 128 = -65152 (wraps to 384, clamps to -32768).
    send_vec("ovf", -128, -128, -128, -128, 127, 127, 127, 127, -128, 0);
    collect("ovf", 1'b0, t0);

    // Backpressure: result held for 3 cycles with out_ready low, while
    // in_valid is asserted with garbage that must not be taken.
    send_vec("bp", 1, 2, 3, 4, 5, 6, 7, 8, 10, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_pre", 32'(pre), 32'd80);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      x        = 16'($urandom);
      w        = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    collect("bp", 1'b0, t0);

    // Gaps: two idle cycles with garbage between the beats.
    send_vec("gap", 1, 2, 3, 4, 5, 6, 7, 8, 10, 2);
    collect("gap", 1'b0, t0);

    // Reset after the first beat discards the partial vector.
    send_beat("rst_mid_b0", 1, 2, 5, 6, 10);
    rst_n = 1'b0;
    tick();
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_pre", 32'(pre), 32'd0);
    tick();
    rst_n = 1'b1;
    check("rst_mid_after_valid", 32'(out_valid), 32'd0);
    send_vec("rst_mid", 1, 2, 3, 4, 5, 6, 7, 8, 10, 0);
    collect("rst_mid", 1'b0, t0);

    // Back-to-back with out_ready tied high: results 3 cycles apart.
    out_ready = 1'b1;
    send_vec("b2b_a", 1, 2, 3, 4, 5, 6, 7, 8, 10, 0);
    collect("b2b_a", 1'b1, t0);
    send_vec("b2b_b", -1, -1, -1, -1, 1, 1, 1, 1, 0, 0);
    collect("b2b_b", 1'b1, t1);
    check("b2b_spacing", 32'(t1 - t0), 32'd3);
    out_ready = 1'b0;

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
